// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: scan state encoding and small index helpers shared by the
// LED matrix scanner and its testbench.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_t;

  // Widest column vector the one-hot helper can produce.
  localparam int ONEHOT_W = 256;

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Column decode: bit idx set, all others clear. Callers cast to COLS bits.
  function automatic logic [ONEHOT_W-1:0] onehot(input int idx);
    return ONEHOT_W'(1) << idx;
  endfunction

  // Flat bit position of cell (r,c) in a frame vector.
  function automatic int cell_index(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: frame transfer handshake into the scanner.
// The producer (cell-state register) owns frame_in/frame_valid, the scanner
// answers with frame_ready.
interface led_matrix_scanner_if #(
  parameter int ROWS = 5,
  parameter int COLS = 5
);
  logic [ROWS*COLS-1:0] frame_in;
  logic                 frame_valid;
  logic                 frame_ready;

  modport master (output frame_in, output frame_valid, input frame_ready);
  modport slave  (input frame_in, input frame_valid, output frame_ready);
endinterface

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double buffer behind the frame handshake. A frame lands
// in the pending register on valid&&ready and is promoted to the display
// register only when the scanner strobes i_swap at a frame boundary.
module led_frame_buffer #(
  parameter int N_CELLS = 25
) (
  input  logic                       clk,
  input  logic                       rst_n,
  led_matrix_scanner_if.slave        bus,
  input  logic                       i_swap,
  output logic [N_CELLS-1:0]         o_display
);

  logic [N_CELLS-1:0] r_pending;
  logic [N_CELLS-1:0] r_display;
  logic               r_pending_full;

  // Ready comes straight from the register so the producer never sees a
  // combinational loop through this block.
  assign bus.frame_ready = ~r_pending_full;
  assign o_display       = r_display;

  // Accept a frame into pending, or hand pending over to display at a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the frame registers are reset too; a dark matrix after reset
      // depends on display being known, and the cost is one flop reset each.
      r_pending      <= '0;
      r_display      <= '0;
      r_pending_full <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples the
      // pre-edge values regardless of statement order.
      if (bus.frame_valid && !r_pending_full) begin
        r_pending      <= bus.frame_in;
        r_pending_full <= 1'b1;
      end else if (i_swap && r_pending_full) begin
        r_display      <= r_pending;
        r_pending_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: self-timed column scanner for an LED matrix. Walks the
// column index, blanks between columns against ghosting, and swaps in a new
// double-buffered frame only at frame boundaries.
// Optional build macro LED_SCANNER_PWM_EN adds a per-frame brightness input
// that shortens the row-on time inside each column dwell.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = 5,
  parameter int COLS         = 5,
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  led_matrix_scanner_if.slave           frame_if,
`ifdef LED_SCANNER_PWM_EN
  input  logic [$clog2(DWELL_CYCLES+1)-1:0] brightness,
`endif
  output logic [ROWS-1:0]               rows,
  output logic [COLS-1:0]               cols,
  output logic [idx_width(COLS)-1:0]    x,
  output logic                          frame_start
);

  localparam int X_W     = idx_width(COLS);
  localparam int CNT_W   = $clog2(max_int(DWELL_CYCLES, BLANK_CYCLES) + 1);
  localparam int N_CELLS = ROWS * COLS;

  // With no blanking, each column (and thus each frame) begins in S_DRIVE.
  localparam scan_state_t FIRST_STATE = (BLANK_CYCLES > 0) ? S_BLANK : S_DRIVE;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [X_W-1:0]   X_LAST     = X_W'(COLS - 1);

  scan_state_t        r_state;
  scan_state_t        w_state_nxt;
  logic [X_W-1:0]     r_x;
  logic [X_W-1:0]     w_x_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_frame_boundary;
  logic [N_CELLS-1:0] w_display;

  led_frame_buffer #(
    .N_CELLS (N_CELLS)
  ) u_frame_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (frame_if),
    .i_swap    (w_frame_boundary),
    .o_display (w_display)
  );

  // Scan state, column index and shared blank/dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next scan position; also flags the edge that enters a new frame.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_cnt_nxt   = r_cnt;

    if (!ena) begin
      w_state_nxt = S_IDLE;
      w_x_nxt     = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = FIRST_STATE;
          w_x_nxt     = '0;
          w_cnt_nxt   = '0;
        end
        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = S_DRIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == DWELL_LAST) begin
            w_cnt_nxt   = '0;
            w_x_nxt     = (r_x == X_LAST) ? '0 : r_x + 1'b1;
            w_state_nxt = FIRST_STATE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_x_nxt     = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // Column 0, count 0 of the first state is only reachable from S_IDLE or
    // from the wrap of the last column, i.e. exactly at a frame start. The
    // swap happens on the edge entering that clock so column 0 already shows
    // the new frame.
    w_frame_boundary = ena && (w_state_nxt == FIRST_STATE) &&
                       (w_x_nxt == '0) && (w_cnt_nxt == '0);
  end

`ifdef LED_SCANNER_PWM_EN
  localparam int BRIGHT_W = $clog2(DWELL_CYCLES + 1);
  logic [BRIGHT_W-1:0] r_bright;

  // Brightness is latched once per frame so a frame is shown at one duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bright <= '0;
    end else if (w_frame_boundary) begin
      r_bright <= brightness;
    end
  end
`endif

  // LED pin decode, purely from registered state.
  always_comb begin
    rows        = '0;
    cols        = '0;
    x           = r_x;
    frame_start = (r_state == FIRST_STATE) && (r_x == '0) && (r_cnt == '0);

    if (r_state == S_DRIVE) begin
      cols = COLS'(onehot(int'(r_x)));
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (c == int'(r_x)) begin
            rows[r] = w_display[cell_index(r, c, COLS)];
          end
        end
      end
`ifdef LED_SCANNER_PWM_EN
      // Rows are on only for the first r_bright clocks of the dwell.
      if (32'(r_cnt) >= 32'(r_bright)) begin
        rows = '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: randomized self-checking bench. Two scanners run
// side by side on the same stimulus, one with a blank clock between columns
// and one without. A behavioural model tracks each as "clocks since the scan
// was enabled" and derives column, blank/drive phase and frame start from
// that count with plain division. Covers the PWM build when
// LED_SCANNER_PWM_EN is defined.
`timescale 1ns/1ps
module tb_led_matrix_scanner;

  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int DWELL = 4;
  localparam int NI    = 2;
  localparam int NC    = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic [NC-1:0] tb_frame;
  logic          tb_valid;
  logic [2:0]    brightness;

  logic [ROWS-1:0] rows_a, rows_b;
  logic [COLS-1:0] cols_a, cols_b;
  logic [2:0]      x_a, x_b;
  logic            fs_a, fs_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) if_a ();
  led_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) if_b ();

  assign if_a.frame_in    = tb_frame;
  assign if_a.frame_valid = tb_valid;
  assign if_b.frame_in    = tb_frame;
  assign if_b.frame_valid = tb_valid;

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(1)
  ) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .frame_if    (if_a),
`ifdef LED_SCANNER_PWM_EN
    .brightness  (brightness),
`endif
    .rows        (rows_a),
    .cols        (cols_a),
    .x           (x_a),
    .frame_start (fs_a)
  );

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(0)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .frame_if    (if_b),
`ifdef LED_SCANNER_PWM_EN
    .brightness  (brightness),
`endif
    .rows        (rows_b),
    .cols        (cols_b),
    .x           (x_b),
    .frame_start (fs_b)
  );

  always #5 clk = ~clk;

  // Reference model state, one slot per scanner instance.
  bit            m_active [NI];
  int            m_p      [NI];
  logic [NC-1:0] m_pend   [NI];
  logic [NC-1:0] m_disp   [NI];
  bit            m_full   [NI];
  int            m_bright [NI];

  function automatic int blank_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int period_of(input int k);
    return COLS * (blank_of(k) + DWELL);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_active[k] = 1'b0;
      m_p[k]      = 0;
      m_pend[k]   = '0;
      m_disp[k]   = '0;
      m_full[k]   = 1'b0;
      m_bright[k] = 0;
    end
  endtask

  // One rising edge of the model, using the inputs as they stood before it.
  task automatic model_edge(input int k);
    bit acc;
    bit bnd;
    acc = tb_valid && !m_full[k];
    bnd = 1'b0;
    if (!ena) begin
      m_active[k] = 1'b0;
      m_p[k]      = 0;
    end else if (!m_active[k]) begin
      m_active[k] = 1'b1;
      m_p[k]      = 0;
      bnd         = 1'b1;
    end else begin
      m_p[k] = (m_p[k] + 1) % period_of(k);
      bnd    = (m_p[k] == 0);
    end
    if (bnd) begin
      m_bright[k] = int'(brightness);
      if (m_full[k]) begin
        m_disp[k] = m_pend[k];
        m_full[k] = 1'b0;
      end
    end
    if (acc) begin
      m_pend[k] = tb_frame;
      m_full[k] = 1'b1;
    end
  endtask

  // True when the model has instance k driving column col.
  function automatic bit model_driving(input int k, input int col);
    int len;
    len = blank_of(k) + DWELL;
    return m_active[k] && (m_p[k] / len == col) && (m_p[k] % len >= blank_of(k));
  endfunction

  task automatic check_inst(input int k, input logic [ROWS-1:0] g_rows, input logic [COLS-1:0] g_cols,
                            input logic [2:0] g_x, input logic g_fs, input logic g_rdy);
    logic [ROWS-1:0] e_rows;
    logic [COLS-1:0] e_cols;
    int e_x, len, col, w, d;
    bit e_fs;
    string n;
    e_rows = '0;
    e_cols = '0;
    e_x    = 0;
    e_fs   = 1'b0;
    if (m_active[k]) begin
      len  = blank_of(k) + DWELL;
      col  = m_p[k] / len;
      w    = m_p[k] % len;
      e_x  = col;
      e_fs = (m_p[k] == 0);
      if (w >= blank_of(k)) begin
        d      = w - blank_of(k);
        e_cols = COLS'(1 << col);
        for (int r = 0; r < ROWS; r++) e_rows[r] = m_disp[k][r * COLS + col];
`ifdef LED_SCANNER_PWM_EN
        if (d >= m_bright[k]) e_rows = '0;
`endif
      end
    end
    n = (k == 0) ? "a" : "b";
    check({"rows_", n}, 32'(g_rows), 32'(e_rows));
    check({"cols_", n}, 32'(g_cols), 32'(e_cols));
    check({"x_", n}, 32'(g_x), e_x);
    check({"frame_start_", n}, 32'(g_fs), 32'(e_fs));
    check({"frame_ready_", n}, 32'(g_rdy), 32'(!m_full[k]));
  endtask

  task automatic compare_all();
    check_inst(0, rows_a, cols_a, x_a, fs_a, if_a.frame_ready);
    check_inst(1, rows_b, cols_b, x_b, fs_b, if_b.frame_ready);
  endtask

  // Advance one clock: model follows the edge, outputs are compared on the
  // falling edge, and the caller then drives the next inputs.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < NI; k++) model_edge(k);
    end
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_a, last_b;

    rst_n      = 1'b0;
    ena        = 1'b0;
    tb_valid   = 1'b0;
    tb_frame   = '0;
    brightness = 3'd4;
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single lit cell (r=1,c=2), loaded before the scan is enabled.
    tb_frame = NC'(1) << 7;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    ena      = 1'b1;
    last_a   = -1;
    last_b   = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (fs_a) begin
        if (last_a >= 0) check("period_a", cyc - last_a, 25);
        last_a = cyc;
      end
      if (fs_b) begin
        if (last_b >= 0) check("period_b", cyc - last_b, 20);
        last_b = cyc;
      end
    end

    // Drop enable while column 3 is being driven, then re-enable.
    for (int i = 0; i < 30 && !model_driving(0, 3); i++) tick();
    check("reached_col3", 32'(model_driving(0, 3)), 32'd1);
    ena = 1'b0;
    tick();
    ena = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Frame A then frame B partway through a scan.
    tb_frame = 25'h1555555;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    tb_frame = 25'h0aaaaaa;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    for (int i = 0; i < 60; i++) tick();

    // Randomized traffic: frames, enable drops and brightness changes.
    for (int i = 0; i < 1500; i++) begin
      ena      = ($urandom_range(0, 39) != 0);
      tb_valid = ($urandom_range(0, 5) == 0);
      tb_frame = NC'($urandom);
      if ($urandom_range(0, 15) == 0) brightness = 3'($urandom_range(0, 7));
      tick();
    end

    // Asynchronous reset mid-scan: outputs must clear before any clock edge.
    ena      = 1'b1;
    tb_frame = '1;
    tb_valid = 1'b1;
    tick();
    tb_valid = 1'b0;
    for (int i = 0; i < 33; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
